// File: rtl/inst_u_enc.sv
// inst_u_enc: packs LUI/AUIPC fields into 32-bit instruction words and
// delivers them through a 2-entry valid/ready FIFO, tagging each head word
// with a sequential byte address and counting words handed off.
module inst_u_enc #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sel,
  input  logic [19:0]       imm,
  input  logic [4:0]        rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              rd_zero,
  output logic [CNT_W-1:0]  enc_count
);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // Positional U-type packing; every immediate value is legal as-is.
  function automatic logic [31:0] encode_u(input logic       op_i,
                                           input logic [19:0] imm_i,
                                           input logic [4:0]  rd_i);
    logic [6:0] opc;
    if (op_i) begin
      opc = OPC_AUIPC;
    end else begin
      opc = OPC_LUI;
    end
    return {imm_i, rd_i, opc};
  endfunction

  // FIFO entries carry {rd_zero, word}; entry 0 is always the head.
  logic [1:0]        occ_q, occ_d;
  logic [32:0]       ent0_q, ent0_d;
  logic [32:0]       ent1_q, ent1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic              push_s;
  logic              pop_s;
  logic [32:0]       new_ent_s;

  assign push_s    = in_valid && in_ready_q;
  assign pop_s     = out_valid_q && out_ready;
  assign new_ent_s = {(rd == 5'd0), encode_u(op_sel, imm, rd)};

  // Next-state: FIFO shift/fill, address advance and saturating count.
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;

    case ({push_s, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          ent0_d = new_ent_s;
        end else begin
          ent1_d = new_ent_s;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        // Only promote the second entry when one is actually buffered.
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
        end else begin
          ent0_d = ent0_q;
        end
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Push and pop together only happens at occupancy 1.
        ent0_d = new_ent_s;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase

    if (pop_s) begin
      addr_d = addr_q + ADDR_W'(32'd4);
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
    end

    out_valid_d = (occ_d != 2'd0);
    in_ready_d  = (occ_d != 2'd2);
  end

  // State register with synchronous reset that discards buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= 2'd0;
      ent0_q      <= 33'd0;
      ent1_q      <= 33'd0;
      addr_q      <= BASE_ADDR;
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      occ_q       <= occ_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign inst_word = ent0_q[31:0];
  assign rd_zero   = ent0_q[32];
  assign out_addr  = addr_q;
  assign enc_count = cnt_q;

endmodule
